ristretto_mem_arbiter: RTL and testbench
========================================

Name: ristretto_mem_arbiter

Overview:
- Shares one unified memory port between the three core-side requesters: instruction fetch, data read (LSU load) and data write (LSU store).
- Sits between the core top-level memory ports and a single-ported memory or bus.
- Allows exactly one outstanding transaction.
- Fixed-priority arbitration with a registered grant, a req/ready/valid handshake on every side, and a response timeout.

Parameters:
DataWidth, 32, data bus width; strobe width is DataWidth/8
AddrWidth, 32, address width
TimeoutCycles, 64, max cycles in RESP before forced error completion; 0 disables the timeout
StarveLimit, 4, consecutive data grants before fetch is forced (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
if_req_i  in  1  fetch request, held until if_ready_o
if_addr_i  in  AddrWidth  fetch address
if_ready_o  out  1  fetch request accepted by memory
if_valid_o  out  1  fetch response valid
if_rdata_o  out  DataWidth  fetch read data
rd_req_i  in  1  load request
rd_addr_i  in  AddrWidth  load address
rd_strb_i  in  DataWidth/8  load byte strobe
rd_ready_o  out  1  load accepted
rd_valid_o  out  1  load response valid
rd_rdata_o  out  DataWidth  load data
wr_req_i  in  1  store request
wr_addr_i  in  AddrWidth  store address
wr_data_i  in  DataWidth  store data
wr_strb_i  in  DataWidth/8  store byte strobe
wr_ready_o  out  1  store accepted
wr_valid_o  out  1  store completion
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  AddrWidth  memory address
mem_wdata_o  out  DataWidth  memory write data
mem_strb_o  out  DataWidth/8  memory byte strobe; all ones for fetch
mem_ready_i  in  1  memory accepts request
mem_valid_i  in  1  memory response valid
mem_rdata_i  in  DataWidth  memory read data
arb_grant_o  out  2  current owner: 0 none, 1 fetch, 2 read, 3 write
arb_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; holding registers 0; counters 0. Reset mid-transaction aborts it silently. The requester must re-issue, and the memory-side response is dropped.
- FSM states: IDLE, REQ, RESP.
- IDLE: if any req_i is high, select by priority write > read > fetch. Latch the selected addr, data, strobe and we into holding registers; set arb_grant_o; go to REQ next cycle. With no request, stay in IDLE with arb_grant_o=0.
- REQ: mem_req_o=1 and mem_* driven from the holding registers only, so they are stable while waiting.
  - mem_ready_i=1: the granted xx_ready_o is high combinationally in that cycle; go to RESP.
  - mem_ready_i=1 and mem_valid_i=1 in the same cycle: ready and valid both pulse; go directly to IDLE.
- RESP: mem_req_o=0.
  - mem_valid_i=1: granted xx_valid_o=1 combinationally; if_rdata_o/rd_rdata_o = mem_rdata_i; go to IDLE, clear grant.
  - Timeout: the timeout counter counts RESP cycles. On reaching TimeoutCycles, assert granted xx_valid_o with rdata 0 and arb_err_o=1 for one cycle; go to IDLE.
  - mem_valid_i arriving after a timeout is ignored.
- mem_valid_i or mem_ready_i outside their state: ignored.
- Non-granted ready/valid outputs are always 0. rdata outputs are 0 when not valid.
- Latency: request seen in cycle N gives mem_req_o in cycle N+1. Best case the response returns to the requester in cycle N+1 (zero-wait memory), and the next arbitration happens in cycle N+2.
- Requests dropped by a requester before ready have no effect once latched; the transaction completes and its response is still delivered.
- Simultaneous requests: the loser stays pending and is re-arbitrated in the next IDLE.

Optional Feature:
RISTRETTO_MEM_ARB_STARVE_GUARD_EN
- Defined: a counter of consecutive read/write grants made while if_req_i was pending. When it reaches StarveLimit, the next IDLE arbitration grants fetch regardless of priority. The counter clears on any fetch grant or when if_req_i=0.
- Undefined: strict priority, fetch may starve, and StarveLimit is unused.

Test Plan:
- Single fetch: if_req_i=1, addr 0x100, mem_ready_i one cycle later, mem_valid_i two cycles later with 0xDEADBEEF -> mem_addr_o=0x100, mem_we_o=0, mem_strb_o=4'hF, if_ready_o then if_valid_o each pulse once, if_rdata_o=0xDEADBEEF, arb_grant_o back to 0.
- All three requesters asserted together -> grant order write (mem_we_o=1, mem_wdata_o=wr_data_i), then read, then fetch; non-granted ready/valid stay 0 throughout.
- Zero-wait memory (mem_ready_i and mem_valid_i high in the same REQ cycle) -> ready and valid pulse together and the FSM returns to IDLE next cycle; back-to-back loads complete one per 2 cycles.
- Timeout: TimeoutCycles=8, mem_valid_i never asserted -> 8 RESP cycles later rd_valid_o=1 with rd_rdata_o=0 and arb_err_o pulses once; a late mem_valid_i is ignored.
- rst_i asserted in RESP -> all outputs 0 immediately; the later mem_valid_i produces no xx_valid_o; the next request arbitrates normally.
- With RISTRETTO_MEM_ARB_STARVE_GUARD_EN and StarveLimit=4: rd_req_i held continuously plus if_req_i -> fetch is granted after exactly 4 read grants.

Source files
------------

// File: rtl/ristretto_mem_arbiter_if.sv
// Bundles the three core-side requester ports and the unified memory port
// of the ristretto memory arbiter; slave is the arbiter's view, master the environment's.
interface ristretto_mem_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 if_req_i;
  logic [AddrWidth-1:0] if_addr_i;
  logic                 if_ready_o;
  logic                 if_valid_o;
  logic [DataWidth-1:0] if_rdata_o;

  logic                 rd_req_i;
  logic [AddrWidth-1:0] rd_addr_i;
  logic [StrbWidth-1:0] rd_strb_i;
  logic                 rd_ready_o;
  logic                 rd_valid_o;
  logic [DataWidth-1:0] rd_rdata_o;

  logic                 wr_req_i;
  logic [AddrWidth-1:0] wr_addr_i;
  logic [DataWidth-1:0] wr_data_i;
  logic [StrbWidth-1:0] wr_strb_i;
  logic                 wr_ready_o;
  logic                 wr_valid_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [StrbWidth-1:0] mem_strb_o;
  logic                 mem_ready_i;
  logic                 mem_valid_i;
  logic [DataWidth-1:0] mem_rdata_i;

  logic [1:0]           arb_grant_o;
  logic                 arb_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ready_o, if_valid_o, if_rdata_o,
    input  rd_req_i, rd_addr_i, rd_strb_i,
    output rd_ready_o, rd_valid_o, rd_rdata_o,
    input  wr_req_i, wr_addr_i, wr_data_i, wr_strb_i,
    output wr_ready_o, wr_valid_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o,
    input  mem_ready_i, mem_valid_i, mem_rdata_i,
    output arb_grant_o, arb_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ready_o, if_valid_o, if_rdata_o,
    output rd_req_i, rd_addr_i, rd_strb_i,
    input  rd_ready_o, rd_valid_o, rd_rdata_o,
    output wr_req_i, wr_addr_i, wr_data_i, wr_strb_i,
    input  wr_ready_o, wr_valid_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o,
    output mem_ready_i, mem_valid_i, mem_rdata_i,
    input  arb_grant_o, arb_err_o
  );
endinterface

// File: rtl/ristretto_mem_arbiter.sv
// Fixed-priority (write > read > fetch) single-outstanding arbiter onto one memory port.
// Define RISTRETTO_MEM_ARB_STARVE_GUARD_EN to force a fetch grant after StarveLimit data grants.
module ristretto_mem_arbiter #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned StarveLimit   = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ristretto_mem_arbiter_if.slave bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned TmoWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_IF = 2'd1, GNT_RD = 2'd2, GNT_WR = 2'd3} grant_e;

  state_e               state;
  grant_e               grant;
  grant_e               sel;
  logic [AddrWidth-1:0] hold_addr;
  logic [DataWidth-1:0] hold_wdata;
  logic [StrbWidth-1:0] hold_strb;
  logic                 hold_we;
  logic [TmoWidth-1:0]  tmo_cnt;
  logic                 starve_force;

  logic in_req, in_resp, accept, data_done, tmo_hit, tmo_done, done;

  assign in_req    = (state == S_REQ);
  assign in_resp   = (state == S_RESP);
  assign accept    = in_req && bus.mem_ready_i;
  assign data_done = (accept || in_resp) && bus.mem_valid_i;
  // The forced completion occupies the TimeoutCycles-th RESP cycle; real data wins a tie.
  assign tmo_hit   = (TimeoutCycles != 0) && (tmo_cnt == TmoWidth'(TimeoutCycles - 1));
  assign tmo_done  = in_resp && !bus.mem_valid_i && tmo_hit;
  assign done      = data_done || tmo_done;

  always_comb begin
    // NOTE: sel gets a default before any branch so no latch is inferred.
    sel = GNT_NONE;
    if (starve_force)        sel = GNT_IF;
    else if (bus.wr_req_i)   sel = GNT_WR;
    else if (bus.rd_req_i)   sel = GNT_RD;
    else if (bus.if_req_i)   sel = GNT_IF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      grant      <= GNT_NONE;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_strb  <= '0;
      hold_we    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      unique case (state)
        S_IDLE: begin
          if (sel != GNT_NONE) begin
            state   <= S_REQ;
            grant   <= sel;
            hold_we <= (sel == GNT_WR);
            unique case (sel)
              GNT_WR: begin
                hold_addr  <= bus.wr_addr_i;
                hold_wdata <= bus.wr_data_i;
                hold_strb  <= bus.wr_strb_i;
              end
              GNT_RD: begin
                hold_addr  <= bus.rd_addr_i;
                hold_wdata <= '0;
                hold_strb  <= bus.rd_strb_i;
              end
              default: begin
                hold_addr  <= bus.if_addr_i;
                hold_wdata <= '0;
                hold_strb  <= '1;
              end
            endcase
          end
        end
        S_REQ: begin
          if (accept) begin
            tmo_cnt <= '0;
            if (bus.mem_valid_i) begin
              state <= S_IDLE;
              grant <= GNT_NONE;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (done) begin
            state <= S_IDLE;
            grant <= GNT_NONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

`ifdef RISTRETTO_MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveWidth = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;

  logic [StarveWidth-1:0] starve_cnt;
  logic                   idle_data_grant;

  assign starve_force    = bus.if_req_i && (starve_cnt >= StarveWidth'(StarveLimit));
  assign idle_data_grant = (state == S_IDLE) && ((sel == GNT_RD) || (sel == GNT_WR));

  // Cannot pass StarveLimit: at the limit a pending fetch takes the next grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (!bus.if_req_i || ((state == S_IDLE) && (sel == GNT_IF))) begin
      starve_cnt <= '0;
    end else if (idle_data_grant) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_force        = 1'b0;
  assign unused_starve_limit = (StarveLimit == 0);
`endif

  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req && hold_we;
  assign bus.mem_addr_o  = in_req ? hold_addr  : '0;
  assign bus.mem_wdata_o = in_req ? hold_wdata : '0;
  assign bus.mem_strb_o  = in_req ? hold_strb  : '0;

  assign bus.if_ready_o  = accept && (grant == GNT_IF);
  assign bus.if_valid_o  = done   && (grant == GNT_IF);
  assign bus.if_rdata_o  = (data_done && (grant == GNT_IF)) ? bus.mem_rdata_i : '0;

  assign bus.rd_ready_o  = accept && (grant == GNT_RD);
  assign bus.rd_valid_o  = done   && (grant == GNT_RD);
  assign bus.rd_rdata_o  = (data_done && (grant == GNT_RD)) ? bus.mem_rdata_i : '0;

  assign bus.wr_ready_o  = accept && (grant == GNT_WR);
  assign bus.wr_valid_o  = done   && (grant == GNT_WR);

  assign bus.arb_grant_o = grant;
  assign bus.arb_err_o   = tmo_done;
endmodule

// File: tb/tb_ristretto_mem_arbiter.sv
// Directed bench for ristretto_mem_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_ristretto_mem_arbiter;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned TimeoutCycles = 8;
  localparam int unsigned StarveLimit   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  ristretto_mem_arbiter_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus ();

  ristretto_mem_arbiter #(
    .DataWidth    (DataWidth),
    .AddrWidth    (AddrWidth),
    .TimeoutCycles(TimeoutCycles),
    .StarveLimit  (StarveLimit)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {if_ready, if_valid, rd_ready, rd_valid, wr_ready, wr_valid, mem_req, arb_err}
  function automatic logic [7:0] hs();
    return {bus.if_ready_o, bus.if_valid_o, bus.rd_ready_o, bus.rd_valid_o,
            bus.wr_ready_o, bus.wr_valid_o, bus.mem_req_o, bus.arb_err_o};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.rd_req_i = 1'b0; bus.rd_addr_i = '0; bus.rd_strb_i = '0;
    bus.wr_req_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_strb_i = '0;
    bus.mem_ready_i = 1'b1; bus.mem_valid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (hs() !== 8'h00) $display("FAIL reset_hs: got %b want %b", hs(), 8'h00); else n_pass++;
    n_checks++; if (bus.arb_grant_o !== 2'd0) $display("FAIL reset_grant: got %0d want 0", bus.arb_grant_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0 || bus.mem_strb_o !== 4'h0 || bus.mem_we_o !== 1'b0)
      $display("FAIL reset_mem: addr %h wdata %h strb %h we %b want all 0", bus.mem_addr_o, bus.mem_wdata_o, bus.mem_strb_o, bus.mem_we_o);
    else n_pass++;
    n_checks++; if (bus.if_rdata_o !== 32'h0 || bus.rd_rdata_o !== 32'h0)
      $display("FAIL reset_rdata: if %h rd %h want 0", bus.if_rdata_o, bus.rd_rdata_o);
    else n_pass++;
    bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    #1;
    n_checks++; if (hs() !== 8'h00) $display("FAIL fetch_idle_hs: got %b want %b", hs(), 8'h00); else n_pass++;
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1;
    n_checks++; if (hs() !== 8'b1000_0010) $display("FAIL fetch_req_hs: got %b want %b", hs(), 8'b1000_0010); else n_pass++;
    n_checks++; if (bus.arb_grant_o !== 2'd1) $display("FAIL fetch_grant: got %0d want 1", bus.arb_grant_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h100 || bus.mem_we_o !== 1'b0 || bus.mem_strb_o !== 4'hF)
      $display("FAIL fetch_mem: addr %h we %b strb %h want 100 0 f", bus.mem_addr_o, bus.mem_we_o, bus.mem_strb_o);
    else n_pass++;
    bus.if_req_i = 1'b0;
    @(negedge clk);
    bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (hs() !== 8'b0100_0000) $display("FAIL fetch_resp_hs: got %b want %b", hs(), 8'b0100_0000); else n_pass++;
    n_checks++; if (bus.if_rdata_o !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h want deadbeef", bus.if_rdata_o); else n_pass++;
    @(negedge clk);
    bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0 || bus.if_rdata_o !== 32'h0)
      $display("FAIL fetch_done: hs %b grant %0d rdata %h want 0 0 0", hs(), bus.arb_grant_o, bus.if_rdata_o);
    else n_pass++;
  endtask

  task automatic test_priority();
    logic [1:0]  e_gnt [3] = '{2'd3, 2'd2, 2'd1};
    logic [31:0] e_addr[3] = '{32'h400, 32'h300, 32'h200};
    logic [3:0]  e_strb[3] = '{4'hC, 4'h3, 4'hF};
    logic [7:0]  e_rdy [3] = '{8'b0000_1010, 8'b0010_0010, 8'b1000_0010};
    logic [7:0]  e_vld [3] = '{8'b0000_0100, 8'b0001_0000, 8'b0100_0000};
    logic [31:0] rdata, e_if, e_rd;
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    bus.rd_req_i = 1'b1; bus.rd_addr_i = 32'h300; bus.rd_strb_i = 4'h3;
    bus.wr_req_i = 1'b1; bus.wr_addr_i = 32'h400; bus.wr_data_i = 32'hCAFE_F00D; bus.wr_strb_i = 4'hC;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0)
        $display("FAIL prio_idle[%0d]: hs %b grant %0d want 0 0", k, hs(), bus.arb_grant_o);
      else n_pass++;
      @(negedge clk);
      bus.mem_ready_i = 1'b1;
      #1;
      n_checks++; if (bus.arb_grant_o !== e_gnt[k]) $display("FAIL prio_grant[%0d]: got %0d want %0d", k, bus.arb_grant_o, e_gnt[k]); else n_pass++;
      n_checks++; if (hs() !== e_rdy[k]) $display("FAIL prio_ready[%0d]: got %b want %b", k, hs(), e_rdy[k]); else n_pass++;
      n_checks++; if (bus.mem_addr_o !== e_addr[k] || bus.mem_strb_o !== e_strb[k] || bus.mem_we_o !== (k == 0))
        $display("FAIL prio_mem[%0d]: addr %h strb %h we %b want %h %h %b", k, bus.mem_addr_o, bus.mem_strb_o, bus.mem_we_o, e_addr[k], e_strb[k], k == 0);
      else n_pass++;
      if (k == 0) begin
        n_checks++; if (bus.mem_wdata_o !== 32'hCAFE_F00D) $display("FAIL prio_wdata: got %h want cafef00d", bus.mem_wdata_o); else n_pass++;
      end
      case (k)
        0:       bus.wr_req_i = 1'b0;
        1:       bus.rd_req_i = 1'b0;
        default: bus.if_req_i = 1'b0;
      endcase
      @(negedge clk);
      rdata = 32'h1111_0000 + 32'(k);
      bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b1; bus.mem_rdata_i = rdata;
      e_if = (k == 2) ? rdata : 32'h0;
      e_rd = (k == 1) ? rdata : 32'h0;
      #1;
      n_checks++; if (hs() !== e_vld[k]) $display("FAIL prio_valid[%0d]: got %b want %b", k, hs(), e_vld[k]); else n_pass++;
      n_checks++; if (bus.if_rdata_o !== e_if || bus.rd_rdata_o !== e_rd)
        $display("FAIL prio_rdata[%0d]: if %h rd %h want %h %h", k, bus.if_rdata_o, bus.rd_rdata_o, e_if, e_rd);
      else n_pass++;
      @(negedge clk);
      bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
    end
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0)
      $display("FAIL prio_end: hs %b grant %0d want 0 0", hs(), bus.arb_grant_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.rd_strb_i = 4'hF;
    bus.mem_ready_i = 1'b1; bus.mem_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.rd_addr_i   = 32'h500 + 32'(4 * k);
      bus.mem_rdata_i = 32'hA000 + 32'(k);
      #1;
      n_checks++; if (hs() !== 8'h00 || bus.rd_rdata_o !== 32'h0 || bus.arb_grant_o !== 2'd0)
        $display("FAIL b2b_idle[%0d]: hs %b rdata %h grant %0d want 0 0 0", k, hs(), bus.rd_rdata_o, bus.arb_grant_o);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (hs() !== 8'b0011_0010) $display("FAIL b2b_hs[%0d]: got %b want %b", k, hs(), 8'b0011_0010); else n_pass++;
      n_checks++; if (bus.mem_addr_o !== 32'h500 + 32'(4 * k) || bus.rd_rdata_o !== 32'hA000 + 32'(k))
        $display("FAIL b2b_data[%0d]: addr %h rdata %h want %h %h", k, bus.mem_addr_o, bus.rd_rdata_o, 32'h500 + 32'(4 * k), 32'hA000 + 32'(k));
      else n_pass++;
      if (k == 2) bus.rd_req_i = 1'b0;
      @(negedge clk);
    end
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0)
      $display("FAIL b2b_end: hs %b grant %0d want 0 0", hs(), bus.arb_grant_o);
    else n_pass++;
    bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
  endtask

  task automatic test_timeout();
    logic [7:0] e_hs;
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.rd_addr_i = 32'h600; bus.rd_strb_i = 4'hF;
    #1;
    n_checks++; if (hs() !== 8'h00) $display("FAIL tmo_idle: got %b want %b", hs(), 8'h00); else n_pass++;
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1;
    n_checks++; if (hs() !== 8'b0010_0010) $display("FAIL tmo_ready: got %b want %b", hs(), 8'b0010_0010); else n_pass++;
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    bus.mem_ready_i = 1'b0; bus.mem_rdata_i = 32'h55AA_55AA;
    for (int r = 1; r <= 8; r++) begin
      e_hs = (r == 8) ? 8'b0001_0001 : 8'h00;
      #1;
      n_checks++; if (hs() !== e_hs || bus.rd_rdata_o !== 32'h0 || bus.arb_grant_o !== 2'd2)
        $display("FAIL tmo_resp[%0d]: hs %b rdata %h grant %0d want %b 0 2", r, hs(), bus.rd_rdata_o, bus.arb_grant_o, e_hs);
      else n_pass++;
      @(negedge clk);
    end
    bus.mem_valid_i = 1'b1;
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.rd_rdata_o !== 32'h0 || bus.arb_grant_o !== 2'd0)
      $display("FAIL tmo_late: hs %b rdata %h grant %0d want 0 0 0", hs(), bus.rd_rdata_o, bus.arb_grant_o);
    else n_pass++;
    @(negedge clk);
    bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h700;
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1;
    n_checks++; if (hs() !== 8'b1000_0010) $display("FAIL rstm_ready: got %b want %b", hs(), 8'b1000_0010); else n_pass++;
    bus.if_req_i = 1'b0;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.arb_grant_o !== 2'd1) $display("FAIL rstm_resp_grant: got %0d want 1", bus.arb_grant_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0 || bus.mem_addr_o !== 32'h0)
      $display("FAIL rstm_async: hs %b grant %0d addr %h want 0 0 0", hs(), bus.arb_grant_o, bus.mem_addr_o);
    else n_pass++;
    @(negedge clk);
    bus.mem_valid_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.if_rdata_o !== 32'h0)
      $display("FAIL rstm_dropped: hs %b rdata %h want 0 0", hs(), bus.if_rdata_o);
    else n_pass++;
    bus.wr_req_i = 1'b1; bus.wr_addr_i = 32'h800; bus.wr_data_i = 32'h1234_5678; bus.wr_strb_i = 4'hF;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (hs() !== 8'b0000_1110 || bus.arb_grant_o !== 2'd3)
      $display("FAIL rstm_next_hs: hs %b grant %0d want %b 3", hs(), bus.arb_grant_o, 8'b0000_1110);
    else n_pass++;
    n_checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h800 || bus.mem_wdata_o !== 32'h1234_5678)
      $display("FAIL rstm_next_mem: we %b addr %h wdata %h want 1 800 12345678", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    else n_pass++;
    bus.wr_req_i = 1'b0;
    @(negedge clk);
    bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b0; bus.mem_rdata_i = '0;
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0)
      $display("FAIL rstm_end: hs %b grant %0d want 0 0", hs(), bus.arb_grant_o);
    else n_pass++;
  endtask

  task automatic test_starve();
    logic [1:0]  e_gnt;
    logic [31:0] e_addr;
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.rd_addr_i = 32'h900; bus.rd_strb_i = 4'hF;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'hA00;
    bus.mem_ready_i = 1'b1; bus.mem_valid_i = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      n_checks++; if (bus.arb_grant_o !== 2'd0) $display("FAIL starve_idle[%0d]: grant %0d want 0", g, bus.arb_grant_o); else n_pass++;
      @(negedge clk);
`ifdef RISTRETTO_MEM_ARB_STARVE_GUARD_EN
      e_gnt = (g < 4) ? 2'd2 : 2'd1;
`else
      e_gnt = 2'd2;
`endif
      e_addr = (e_gnt == 2'd1) ? 32'hA00 : 32'h900;
      #1;
      n_checks++; if (bus.arb_grant_o !== e_gnt || bus.mem_addr_o !== e_addr)
        $display("FAIL starve_grant[%0d]: grant %0d addr %h want %0d %h", g, bus.arb_grant_o, bus.mem_addr_o, e_gnt, e_addr);
      else n_pass++;
      if (g == 4) begin
        bus.rd_req_i = 1'b0;
        bus.if_req_i = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (hs() !== 8'h00 || bus.arb_grant_o !== 2'd0)
      $display("FAIL starve_end: hs %b grant %0d want 0 0", hs(), bus.arb_grant_o);
    else n_pass++;
    bus.mem_ready_i = 1'b0; bus.mem_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_starve();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
